// File: rtl/ifm_addr_gen.sv
// IFM read-address generator: walks oy, ox, ky, kx, c over a valid-only convolution
// and issues BRAM byte addresses, with one-cycle-delayed data_valid and window/frame flags.
module ifm_addr_gen #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_cw,
  input  logic              cfg_k3,
  input  logic              cfg_s2,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              data_valid,
  output logic              win_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  cw_max_q, cw_max_d, ow_max_q, ow_max_d, oh_max_q, oh_max_d;
  logic [1:0]        k_max_q, k_max_d;
  logic [WA_W-1:0]   px_step_q, px_step_d, row_step_q, row_step_d, oy_step_q, oy_step_d;
  logic [DIM_W-1:0]  c_q, c_d, ox_q, ox_d, oy_q, oy_d;
  logic [1:0]        kx_q, kx_d, ky_q, ky_d;
  logic [WA_W-1:0]   cur_q, cur_d, row_q, row_d, win_q, win_d, orow_q, orow_d;
  logic              wl_iss_q, wl_iss_d, fl_iss_q, fl_iss_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d, data_valid_q, data_valid_d;
  logic              win_last_q, win_last_d, frame_last_q, frame_last_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic [DIM_W-1:0]  k_in;
  logic              legal;
  logic [WA_W-1:0]   row_step_in;
  logic              last_c, last_kx, last_ky, last_ox, last_oy;

  // Config decode; the multiply only feeds the step registers at start time
  always_comb begin
    k_in        = cfg_k3 ? DIM_W'(3) : DIM_W'(1);
    legal       = (cfg_w >= k_in) && (cfg_h >= k_in) && (cfg_cw != '0);
    row_step_in = WA_W'(cfg_w) * WA_W'(cfg_cw);
  end

  always_comb begin
    last_c  = (c_q == cw_max_q);
    last_kx = (kx_q == k_max_q);
    last_ky = (ky_q == k_max_q);
    last_ox = (ox_q == ow_max_q);
    last_oy = (oy_q == oh_max_q);
  end

  always_comb begin
    state_d      = state_q;
    cw_max_d     = cw_max_q;
    ow_max_d     = ow_max_q;
    oh_max_d     = oh_max_q;
    k_max_d      = k_max_q;
    px_step_d    = px_step_q;
    row_step_d   = row_step_q;
    oy_step_d    = oy_step_q;
    c_d          = c_q;
    kx_d         = kx_q;
    ky_d         = ky_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    cur_d        = cur_q;
    row_d        = row_q;
    win_d        = win_q;
    orow_d       = orow_q;
    wl_iss_d     = wl_iss_q;
    fl_iss_d     = fl_iss_q;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = 1'b0;
    done_d       = 1'b0;
    cfg_err_d    = cfg_err_q;
    data_valid_d = rd_en_q;
    win_last_d   = rd_en_q & wl_iss_q;
    frame_last_d = rd_en_q & fl_iss_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_err_d = ~legal;
          if (!legal) begin
            done_d = 1'b1;
          end else begin
            state_d    = RUN;
            cw_max_d   = cfg_cw - DIM_W'(1);
            k_max_d    = cfg_k3 ? 2'd2 : 2'd0;
            ow_max_d   = (cfg_w - k_in) >> cfg_s2;
            oh_max_d   = (cfg_h - k_in) >> cfg_s2;
            px_step_d  = WA_W'(cfg_cw) << cfg_s2;
            row_step_d = row_step_in;
            oy_step_d  = row_step_in << cfg_s2;
            c_d        = '0;
            kx_d       = '0;
            ky_d       = '0;
            ox_d       = '0;
            oy_d       = '0;
            cur_d      = '0;
            row_d      = '0;
            win_d      = '0;
            orow_d     = '0;
            wl_iss_d   = 1'b0;
            fl_iss_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (fl_iss_q) begin
          state_d = DRAIN;
        end else if (out_ready) begin
          rd_en_d   = 1'b1;
          rd_addr_d = {cur_q, 2'b00};
          wl_iss_d  = last_c & last_kx & last_ky;
          fl_iss_d  = last_c & last_kx & last_ky & last_ox & last_oy;
          // Innermost-first carry chain; each level restarts from its own base
          if (!last_c) begin
            c_d   = c_q + DIM_W'(1);
            cur_d = cur_q + WA_W'(1);
          end else begin
            c_d = '0;
            if (!last_kx) begin
              kx_d  = kx_q + 2'd1;
              cur_d = cur_q + WA_W'(1);
            end else begin
              kx_d = '0;
              if (!last_ky) begin
                ky_d  = ky_q + 2'd1;
                row_d = row_q + row_step_q;
                cur_d = row_q + row_step_q;
              end else begin
                ky_d = '0;
                if (!last_ox) begin
                  ox_d  = ox_q + DIM_W'(1);
                  win_d = win_q + px_step_q;
                  row_d = win_q + px_step_q;
                  cur_d = win_q + px_step_q;
                end else if (!last_oy) begin
                  ox_d   = '0;
                  oy_d   = oy_q + DIM_W'(1);
                  orow_d = orow_q + oy_step_q;
                  win_d  = orow_q + oy_step_q;
                  row_d  = orow_q + oy_step_q;
                  cur_d  = orow_q + oy_step_q;
                end
              end
            end
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cw_max_q     <= '0;
      ow_max_q     <= '0;
      oh_max_q     <= '0;
      k_max_q      <= '0;
      px_step_q    <= '0;
      row_step_q   <= '0;
      oy_step_q    <= '0;
      c_q          <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      cur_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      orow_q       <= '0;
      wl_iss_q     <= 1'b0;
      fl_iss_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      data_valid_q <= 1'b0;
      win_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cw_max_q     <= cw_max_d;
      ow_max_q     <= ow_max_d;
      oh_max_q     <= oh_max_d;
      k_max_q      <= k_max_d;
      px_step_q    <= px_step_d;
      row_step_q   <= row_step_d;
      oy_step_q    <= oy_step_d;
      c_q          <= c_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      cur_q        <= cur_d;
      row_q        <= row_d;
      win_q        <= win_d;
      orow_q       <= orow_d;
      wl_iss_q     <= wl_iss_d;
      fl_iss_q     <= fl_iss_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      data_valid_q <= data_valid_d;
      win_last_q   <= win_last_d;
      frame_last_q <= frame_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_en      = rd_en_q;
  assign data_valid = data_valid_q;
  assign win_last   = win_last_q;
  assign frame_last = frame_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_ifm_addr_gen.sv
// Directed bench for ifm_addr_gen: one task per scenario, expected values hand-derived
// or produced by a direct-formula address model.
module tb_ifm_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_k3, cfg_s2, out_ready;
  logic [7:0]  cfg_w, cfg_h, cfg_cw;
  logic [19:0] rd_addr;
  logic        rd_en, data_valid, win_last, frame_last, busy, done, cfg_err;

  ifm_addr_gen #(.ADDR_W(20), .DIM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_cw(cfg_cw), .cfg_k3(cfg_k3), .cfg_s2(cfg_s2),
    .out_ready(out_ready), .rd_addr(rd_addr), .rd_en(rd_en), .data_valid(data_valid),
    .win_last(win_last), .frame_last(frame_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_dv_cyc = -1;
  logic [19:0] addr_q[$];
  logic [19:0] exp_q[$];
  bit          wl_q[$];
  bit          fl_q[$];

  // Monitor: records every issue, data beat and done pulse after outputs settle
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rd_en) addr_q.push_back(rd_addr);
    if (data_valid) begin
      wl_q.push_back(win_last);
      fl_q.push_back(frame_last);
      last_dv_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon;
    addr_q.delete();
    wl_q.delete();
    fl_q.delete();
    done_cnt    = 0;
    done_cyc    = -1;
    last_dv_cyc = -1;
  endtask

  task automatic model(input int w, input int h, input int cw, input bit k3, input bit s2);
    int k, s, ow, oh;
    k  = k3 ? 3 : 1;
    s  = s2 ? 2 : 1;
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    exp_q.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            for (int c = 0; c < cw; c++)
              exp_q.push_back(20'((((oy*s + ky)*w + ox*s + kx)*cw + c) * 4));
  endtask

  task automatic start_frame(input int w, input int h, input int cw, input bit k3,
                             input bit s2, output int scyc);
    @(negedge clk);
    cfg_w  = 8'(w);
    cfg_h  = 8'(h);
    cfg_cw = 8'(cw);
    cfg_k3 = k3;
    cfg_s2 = s2;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    scyc   = cyc;
  endtask

  // Bounded wait for done; optionally toggles out_ready and injects a start while busy
  task automatic wait_done(input bit toggle, input bit poke, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      if (toggle) out_ready = ~out_ready;
      if (poke && i == 5) begin
        cfg_w = 8'd2; cfg_h = 8'd1; cfg_cw = 8'd2; cfg_k3 = 1'b0; start = 1'b1;
      end
      if (poke && i == 6) start = 1'b0;
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    cfg_w = '0; cfg_h = '0; cfg_cw = '0; cfg_k3 = 1'b0; cfg_s2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_addr !== 20'd0) begin
      errors++; $display("FAIL reset_rd_addr got %0h want 0", rd_addr);
    end
    checks++;
    if ({rd_en, data_valid, win_last, frame_last, busy, done, cfg_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {rd_en, data_valid, win_last, frame_last, busy, done, cfg_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_3x3_s1;
    int scyc, bad, fl_cnt;
    bit ok;
    int w0[9] = '{0, 4, 8, 16, 20, 24, 32, 36, 40};
    clear_mon();
    model(4, 4, 1, 1'b1, 1'b0);
    start_frame(4, 4, 1, 1'b1, 1'b0, scyc);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL s1_busy got %b want 1", busy); end
    wait_done(1'b0, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL s1_timeout done_cnt %0d want 1", done_cnt); end
    checks++;
    if (addr_q.size() != 36) begin
      errors++; $display("FAIL s1_issue_count got %0d want 36", addr_q.size());
    end
    checks++;
    bad = 0;
    for (int i = 0; i < 9 && i < addr_q.size(); i++) if (addr_q[i] !== 20'(w0[i])) bad++;
    if (bad != 0 || addr_q.size() < 10) begin
      errors++; $display("FAIL s1_window0 mismatches %0d size %0d want 0", bad, addr_q.size());
    end
    checks++;
    if (addr_q.size() > 9 && addr_q[9] !== 20'd4) begin
      errors++; $display("FAIL s1_window1_start got %0d want 4", addr_q[9]);
    end
    checks++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) bad++;
    if (bad != 0) begin errors++; $display("FAIL s1_sequence mismatches %0d want 0", bad); end
    checks++;
    bad = 0; fl_cnt = 0;
    for (int i = 0; i < wl_q.size(); i++) begin
      if (wl_q[i] !== (((i + 1) % 9) == 0)) bad++;
      if (fl_q[i]) fl_cnt++;
    end
    if (bad != 0 || wl_q.size() != 36) begin
      errors++; $display("FAIL s1_win_last mismatches %0d beats %0d want 0/36", bad, wl_q.size());
    end
    checks++;
    if (fl_cnt != 1 || fl_q.size() != 36 || fl_q[35] !== 1'b1) begin
      errors++; $display("FAIL s1_frame_last count %0d want 1 on beat 36", fl_cnt);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL s1_done count %0d busy %b want 1/0", done_cnt, busy);
    end
  endtask

  task automatic test_stride2;
    int scyc, bad;
    bit ok;
    clear_mon();
    model(5, 5, 1, 1'b1, 1'b1);
    start_frame(5, 5, 1, 1'b1, 1'b1, scyc);
    wait_done(1'b0, 1'b0, ok);
    checks++;
    if (!ok || addr_q.size() != 36) begin
      errors++; $display("FAIL s2_count got %0d ok %b want 36", addr_q.size(), ok);
    end
    checks++;
    if (addr_q.size() != 36 || addr_q[0] !== 20'd0 || addr_q[9] !== 20'd8 ||
        addr_q[18] !== 20'd40 || addr_q[27] !== 20'd48) begin
      errors++; $display("FAIL s2_window_starts size %0d want words 0,2,10,12", addr_q.size());
    end
    checks++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) bad++;
    if (bad != 0) begin errors++; $display("FAIL s2_sequence mismatches %0d want 0", bad); end
  endtask

  task automatic test_1x1;
    int scyc;
    bit ok;
    logic [19:0] e[4] = '{20'd0, 20'd4, 20'd8, 20'd12};
    clear_mon();
    start_frame(2, 1, 2, 1'b0, 1'b0, scyc);
    wait_done(1'b0, 1'b0, ok);
    checks++;
    if (!ok || addr_q.size() != 4 || addr_q[0] !== e[0] || addr_q[1] !== e[1] ||
        addr_q[2] !== e[2] || addr_q[3] !== e[3]) begin
      errors++; $display("FAIL k1_addrs size %0d ok %b want 0,4,8,12", addr_q.size(), ok);
    end
    checks++;
    if (wl_q.size() != 4 || {wl_q[0], wl_q[1], wl_q[2], wl_q[3]} !== 4'b0101 ||
        {fl_q[0], fl_q[1], fl_q[2], fl_q[3]} !== 4'b0001) begin
      errors++; $display("FAIL k1_flags beats %0d want wl 0101 fl 0001", wl_q.size());
    end
    checks++;
    if (done_cyc != last_dv_cyc + 1) begin
      errors++; $display("FAIL k1_done_timing done %0d last_dv %0d want +1", done_cyc, last_dv_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int scyc, bad;
    bit ok;
    clear_mon();
    model(4, 4, 1, 1'b1, 1'b0);
    start_frame(4, 4, 1, 1'b1, 1'b0, scyc);
    wait_done(1'b1, 1'b1, ok);
    checks++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) bad++;
    if (!ok || bad != 0 || addr_q.size() != 36) begin
      errors++;
      $display("FAIL bp_sequence mismatches %0d size %0d ok %b want 0/36", bad, addr_q.size(), ok);
    end
    checks++;
    if (wl_q.size() != 36) begin
      errors++; $display("FAIL bp_dv_count got %0d want 36", wl_q.size());
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_illegal;
    int scyc;
    bit ok;
    clear_mon();
    start_frame(2, 4, 1, 1'b1, 1'b0, scyc);
    repeat (5) @(negedge clk);
    checks++;
    if (addr_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ill_no_issue issues %0d busy %b want 0/0", addr_q.size(), busy);
    end
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL ill_cfg_err got %b want 1", cfg_err); end
    checks++;
    if (done_cnt != 1 || done_cyc != scyc) begin
      errors++; $display("FAIL ill_done cnt %0d cyc %0d want 1 at %0d", done_cnt, done_cyc, scyc);
    end
    clear_mon();
    start_frame(2, 1, 2, 1'b0, 1'b0, scyc);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", cfg_err); end
    wait_done(1'b0, 1'b0, ok);
    checks++;
    if (!ok || addr_q.size() != 4) begin
      errors++; $display("FAIL ill_recover issues %0d want 4", addr_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int scyc, dv_snap, bad;
    bit ok;
    clear_mon();
    start_frame(4, 4, 1, 1'b1, 1'b0, scyc);
    for (int i = 0; i < 200 && addr_q.size() < 10; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_addr, rd_en, data_valid, win_last, frame_last, busy, done, cfg_err} !== 27'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs addr %0h flags %b want 0", rd_addr,
               {rd_en, data_valid, win_last, frame_last, busy, done, cfg_err});
    end
    rst_n = 1'b1;
    dv_snap = wl_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != 0 || wl_q.size() != dv_snap) begin
      errors++;
      $display("FAIL rst_mid_abort done %0d dv %0d want 0/%0d", done_cnt, wl_q.size(), dv_snap);
    end
    clear_mon();
    model(4, 4, 1, 1'b1, 1'b0);
    start_frame(4, 4, 1, 1'b1, 1'b0, scyc);
    wait_done(1'b0, 1'b0, ok);
    checks++;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_q[i]) bad++;
    if (!ok || bad != 0 || addr_q.size() == 0 || addr_q[0] !== 20'd0) begin
      errors++; $display("FAIL rst_mid_replay mismatches %0d size %0d want 0/36", bad, addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_3x3_s1();
    test_stride2();
    test_1x1();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
